// File: rtl/fm_tx_pkg.sv
// fm_tx_pkg: register map, control opcodes and state encodings for the FM transmitter
package fm_tx_pkg;
  localparam int unsigned ADDR_CTRL = 'h004;
  localparam int unsigned ADDR_CARRIER = 'h008;
  localparam int unsigned ADDR_DEV_GAIN = 'h00C;
  localparam int unsigned ADDR_SAMPLE_DIV = 'h010;
  localparam int unsigned ADDR_AUDIO = 'h014;
  localparam int unsigned ADDR_STATUS = 'h018;
  localparam logic [3:0] OP_START = 4'b0001;
  localparam logic [3:0] OP_STOP = 4'b0010;
  typedef enum logic [3:0] {
    IDLE = 4'b0000,
    PRIME = 4'b0001,
    RUN = 4'b0010
  } state_t;
endpackage

// File: rtl/fm_tx_fifo.sv
// fm_tx_fifo: synchronous audio sample FIFO with flush and simultaneous push/pop when full
module fm_tx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic RSTn,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [7:0] din,
  output logic [7:0] dout,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fm_tx_modulator.sv
// fm_tx_modulator: bus-programmed FM transmitter, audio FIFO feeding a 32-bit NCO
module fm_tx_modulator
  import fm_tx_pkg::*;
#(
  parameter int FM_ADDR_WIDTH = 13,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic RSTn,
  input logic [FM_ADDR_WIDTH-1:0] wraddr,
  input logic [FM_ADDR_WIDTH-1:0] rdaddr,
  input logic [31:0] wdata,
  input logic [3:0] wea,
  output logic [31:0] rdata,
  output logic [3:0] FM_TX_state,
  output logic fifo_low_interrupt,
  output logic underflow_interrupt,
  output logic rf_out,
  output logic [7:0] phase_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HALF = CW'(FIFO_DEPTH / 2);
  state_t state, next_state;
  logic [31:0] carrier, fcw, phase, rd_mux;
  logic [15:0] dev_gain, sample_div, divider;
  logic signed [7:0] sample;
  logic signed [24:0] prod;
  logic [7:0] head;
  logic [CW-1:0] count;
  logic full, empty, overflow, underflow;
  logic wr, ctrl_wr, start, stop, clr, push, strobe;
  assign wr = wea == 4'hf;
  assign ctrl_wr = wr && wraddr == FM_ADDR_WIDTH'(ADDR_CTRL);
  assign start = ctrl_wr && wdata[7:4] == OP_START;
  assign stop = ctrl_wr && wdata[7:4] == OP_STOP;
  assign clr = ctrl_wr && wdata[1:0] == 2'b11;
  assign push = wr && wraddr == FM_ADDR_WIDTH'(ADDR_AUDIO);
  assign strobe = state == RUN && divider == sample_div;
  assign prod = 25'(sample) * 25'($signed({1'b0, dev_gain}));
  assign FM_TX_state = state;
  assign rf_out = phase[31];
  assign phase_out = phase[31:24];
  fm_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .RSTn(RSTn),
    .push(push),
    .pop(strobe),
    .flush(stop),
    .din(wdata[7:0]),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    next_state = stop ? IDLE :
                 (state == IDLE && start) ? PRIME :
                 (state == PRIME && count >= HALF) ? RUN : state;
  end
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      carrier <= '0;
      dev_gain <= '0;
      sample_div <= '0;
    end else if (wr) begin
      if (wraddr == FM_ADDR_WIDTH'(ADDR_CARRIER)) carrier <= wdata;
      if (wraddr == FM_ADDR_WIDTH'(ADDR_DEV_GAIN)) dev_gain <= wdata[15:0];
      if (wraddr == FM_ADDR_WIDTH'(ADDR_SAMPLE_DIV)) sample_div <= wdata[15:0];
    end
  end
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      phase <= '0;
      divider <= '0;
      sample <= '0;
      fcw <= '0;
    end else begin
      phase <= stop ? '0 : state == RUN ? phase + fcw : phase;
      divider <= stop ? '0 : state == RUN ? (strobe ? '0 : divider + 1'b1) : divider;
      sample <= (state == IDLE && start) ? '0 : (strobe && !empty) ? head : sample;
      fcw <= carrier + {{7{prod[24]}}, prod};
    end
  end
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
      underflow_interrupt <= 1'b0;
      fifo_low_interrupt <= 1'b0;
    end else begin
      overflow <= (overflow && !clr) || (push && full && !strobe);
      underflow <= (underflow && !clr) || (strobe && empty);
      underflow_interrupt <= strobe && empty;
      fifo_low_interrupt <= strobe && !push && !stop && count == HALF;
    end
  end
  always_comb begin
    rd_mux = '0;
    rd_mux = rdaddr == FM_ADDR_WIDTH'(ADDR_CARRIER) ? carrier :
             rdaddr == FM_ADDR_WIDTH'(ADDR_DEV_GAIN) ? {16'b0, dev_gain} :
             rdaddr == FM_ADDR_WIDTH'(ADDR_SAMPLE_DIV) ? {16'b0, sample_div} :
             rdaddr == FM_ADDR_WIDTH'(ADDR_STATUS) ? {16'b0, 8'(count), 2'b0, overflow, underflow, state} : '0;
  end
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) rdata <= '0;
    else rdata <= rd_mux;
  end
endmodule

// File: doc/fm_tx_modulator.md
# fm_tx_modulator

Bus-programmed FM transmitter: the core writes signed 8-bit audio samples into an internal FIFO and sets the carrier/deviation registers, and the block produces a frequency-modulated carrier via a 32-bit phase accumulator (NCO). It is the transmit counterpart of the FM receiver hardware. It sits on the same word-addressed register bus (wraddr/rdaddr/wdata/wea/rdata). Its rf_out can be looped into the receiver front end for self-test.

## Interface
- FM_ADDR_WIDTH, 13, register bus address width
- FIFO_DEPTH, 16, audio FIFO entries (power of 2, ≥4)
- clk  in  1  system clock; one clock domain, all logic on posedge
- RSTn  in  1  asynchronous active-low reset
- wraddr  in  FM_ADDR_WIDTH  write address
- rdaddr  in  FM_ADDR_WIDTH  read address
- wdata  in  32  write data
- wea  in  4  byte enables; a write takes effect only when wea==4'hf
- rdata  out  32  registered read data
- FM_TX_state  out  4  current state encoding
- fifo_low_interrupt  out  1  one-cycle pulse, FIFO fell below half
- underflow_interrupt  out  1  one-cycle pulse, sample strobe on empty FIFO
- rf_out  out  1  square-wave FM carrier, phase[31]
- phase_out  out  8  phase[31:24], for LUT-based sine downstream

## Operation
- Registers (write): 0x004 CTRL: wdata[7:4]==4'b0001 start, 4'b0010 stop, other values ignored. 0x008 CARRIER: 32-bit FCW. 0x00C DEV_GAIN: wdata[15:0], unsigned. 0x010 SAMPLE_DIV: wdata[15:0]; an audio sample period is SAMPLE_DIV+1 clocks. 0x014 AUDIO: push wdata[7:0] (signed) into the FIFO.
- Register (read): 0x018 STATUS = {16'b0, fifo_count[7:0], 2'b0, overflow, underflow, FM_TX_state}. 0x008/0x00C/0x010 read back their values. Any other address reads 0.
- States: IDLE=4'b0000, PRIME=4'b0001, RUN=4'b0010.
  - IDLE → PRIME on start.
  - PRIME → RUN when fifo_count ≥ FIFO_DEPTH/2.
  - Any state → IDLE on stop.
  - Start while in PRIME or RUN is ignored.
- Entering IDLE: phase is cleared, the FIFO is flushed, the divider is cleared, and the sticky flags are kept.
- The STATUS-read side effect does not clear the sticky flags. Writing 0x004 with wdata[1:0]==2'b11 clears them.
- FCW = CARRIER + sext32(sample × DEV_GAIN). The product is signed 8 × unsigned 16 → signed 24 bits. The sum wraps modulo 2^32.
- phase += FCW every clock in RUN; phase holds in PRIME and IDLE.
- Sample strobe fires in RUN when divider == SAMPLE_DIV, after which the divider resets to 0. On the strobe:
  - FIFO non-empty: pop the head sample.
  - FIFO empty: hold the previous sample, set the underflow sticky flag, pulse underflow_interrupt.
- Push while full: the write is dropped and the overflow sticky flag is set.
- Push and pop in the same cycle: the count is unchanged and both take effect, including when the FIFO is full. When the FIFO is empty, the pop is an underflow and the push is stored.
- fifo_low_interrupt pulses when fifo_count goes from FIFO_DEPTH/2 to FIFO_DEPTH/2−1, in RUN only.
- The current sample resets to 0 at start, so FCW equals CARRIER until the first pop.

## Timing
- Reset values: FM_TX_state=IDLE, rdata=0, rf_out=0, phase_out=0, both interrupts 0. All registers and the FIFO are cleared.
- Register write takes effect in the cycle after the write edge.
- rdata is valid one clock after rdaddr is presented.
- Pop to FCW latency: the strobe cycle pops the FIFO; the sample register is updated at the next edge; the FCW register is updated one edge later. The phase uses the new FCW from the third edge after the strobe.
- rf_out and phase_out are registered directly from the phase register, with no extra latency.
- Stop takes effect at the next edge: rf_out=0 and fifo_count=0 one cycle after the stop write.
- Reset asserted mid-RUN clears everything asynchronously. There is no partial state after release.
- Interrupts are exactly one cycle wide and registered.

## Structure
- Package fm_tx_pkg holds:
  - register addresses 0x004–0x018
  - CTRL opcodes 4'b0001/4'b0010
  - state encodings IDLE/PRIME/RUN
- Sub-module fm_tx_fifo: synchronous FIFO, parameter FIFO_DEPTH. Ports: push, pop, din[7:0], dout[7:0], count, full, empty, flush. The pointers wrap naturally at the power-of-2 depth.

## Test plan
- Reset, then read 0x018 → rdata=0. Check rf_out=0, FM_TX_state=4'b0000.
- Program CARRIER=0x4000_0000, DEV_GAIN=0, SAMPLE_DIV=3, push 8 samples, start → state goes PRIME then RUN. rf_out toggles every 2 clocks with period 4.
- Program CARRIER=0x1000_0000, DEV_GAIN=0x0100, sample −128 at head → after the strobe + 2 edges, FCW=0x0FFF_8000. The phase increment is checked via phase_out.
- In RUN with SAMPLE_DIV=0, stop pushing → fifo_low_interrupt pulses once at count 8→7. The first strobe on an empty FIFO pulses underflow_interrupt and sets STATUS bit 4, and FCW holds the last sample.
- Push 17 samples with FIFO_DEPTH=16 → fifo_count=16 and the overflow bit is set. Push and pop in the same cycle while full → count stays 16.
- Assert RSTn low mid-RUN → all outputs go to 0 immediately. Stop write during RUN → IDLE, fifo_count=0 next cycle, sticky flags are retained until the clear write.
